mem_dma_copy: RTL and testbench

MEM_DMA_COPY -- requirements
Module: mem_dma_copy

---
 rtl/mem_dma_copy.sv | 121 ++++++++++++
 tb/tb_mem_dma_copy.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_dma_copy.sv
// Block copy engine driving a dual-port RAM: reads on port A, writes on port B.
// Forward-overlapping blocks are copied from the top down so no source word is clobbered before it is read.
module mem_dma_copy #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MEM_WIDTH-1:0]  src,
  input  logic [MEM_WIDTH-1:0]  dst,
  input  logic [MEM_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  we_a,
  output logic [MEM_WIDTH-1:0]  addr_a,
  output logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] out_a,
  output logic                  we_b,
  output logic [MEM_WIDTH-1:0]  addr_b,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state, state_next;
  logic [MEM_WIDTH-1:0] src_q, dst_q, len_q, cnt;
  logic                 desc_q;
  logic                 overlap;
  logic [MEM_WIDTH-1:0] wr_idx;
  logic [MEM_WIDTH-1:0] rd_idx;

  // Forward overlap: destination starts inside the source block, above it.
  assign overlap = (dst > src) && ((dst - src) < len);

  function automatic logic [MEM_WIDTH-1:0] offset(
    input logic                 desc,
    input logic [MEM_WIDTH-1:0] n,
    input logic [MEM_WIDTH-1:0] idx
  );
    offset = desc ? (n - 1'b1 - idx) : idx;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      desc_q <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            src_q  <= src;
            dst_q  <= dst;
            len_q  <= len;
            desc_q <= overlap;
            cnt    <= '0;
          end
        end
        RUN:     cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (len == '0) ? DONE : RUN;
      RUN:     if (cnt == len_q - 1'b1) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The write side trails the read side by one cycle to absorb the RAM read latency.
  assign wr_idx = cnt - 1'b1;
  assign rd_idx = (state == DRAIN) ? wr_idx : cnt;

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    we_b   = 1'b0;
    addr_a = '0;
    addr_b = '0;
    data_b = '0;
    if (!rst) begin
      case (state)
        RUN: begin
          busy   = 1'b1;
          addr_a = src_q + offset(desc_q, len_q, rd_idx);
          if (cnt != '0) begin
            we_b   = 1'b1;
            addr_b = dst_q + offset(desc_q, len_q, wr_idx);
            data_b = out_a;
          end
        end
        DRAIN: begin
          busy   = 1'b1;
          addr_a = src_q + offset(desc_q, len_q, rd_idx);
          we_b   = 1'b1;
          addr_b = dst_q + offset(desc_q, len_q, wr_idx);
          data_b = out_a;
        end
        DONE:    done = 1'b1;
        default: ;
      endcase
    end
  end

  assign we_a      = 1'b0;
  assign data_a    = '0;
  assign fsm_state = state;

endmodule

// File: tb/tb_mem_dma_copy.sv
// Bench for mem_dma_copy: a behavioural RAM plus a memmove-style reference for every copy.
module tb_mem_dma_copy;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW-1:0] src, dst, len;
  logic          busy, done, we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b, out_a;
  logic [1:0]    fsm_state;

  logic [DW-1:0] mem [0:DEPTH-1];
  int n_checks = 0;
  int n_errors = 0;

  mem_dma_copy #(.DATA_WIDTH(DW), .MEM_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .we_a(we_a), .addr_a(addr_a), .data_a(data_a),
    .out_a(out_a), .we_b(we_b), .addr_b(addr_b), .data_b(data_b),
    .fsm_state(fsm_state)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    out_a <= mem[addr_a];
    if (we_b) mem[addr_b] <= data_b;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full copy; expected results come from a memmove reference on a snapshot.
  task automatic run_copy(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW-1:0] l, input bit hold);
    logic [DW-1:0] snap [0:DEPTH-1];
    logic [DW-1:0] exp_mem [0:DEPTH-1];
    logic [AW-1:0] exp_rd[$];
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] a;
    logic          desc;
    int c, bcnt, wcnt, viol, rd_bad, wr_bad, bad, n;
    bit got;
    n = int'(l);
    desc = (d > s) && ((d - s) < l);
    for (int k = 0; k < n; k++) begin
      a = desc ? AW'(int'(s) + n - 1 - k) : AW'(int'(s) + k);
      exp_rd.push_back(a);
      a = desc ? AW'(int'(d) + n - 1 - k) : AW'(int'(d) + k);
      exp_q.push_back(a);
    end
    snap = mem;
    exp_mem = mem;
    for (int k = 0; k < n; k++) exp_mem[AW'(int'(d) + k)] = snap[AW'(int'(s) + k)];

    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = l;
    @(posedge clk);
    #1;
    if (!hold) begin
      start = 1'b0; src = AW'($urandom); dst = AW'($urandom); len = AW'($urandom);
    end
    c = 0; bcnt = 0; wcnt = 0; viol = 0; rd_bad = 0; wr_bad = 0; got = 1'b0;
    while (!got && c < 1000) begin
      @(negedge clk);
      c++;
      if (hold) src = AW'($urandom);
      if (busy) bcnt++;
      if (we_a || data_a != '0) viol++;
      if (!we_b && data_b != '0) viol++;
      if (c <= n && addr_a != exp_rd[c-1]) rd_bad++;
      if (we_b) begin
        wcnt++;
        if (wcnt > n || addr_b != exp_q[wcnt-1]) wr_bad++;
      end
      if (done) begin
        got = 1'b1;
        if (busy || we_b) viol++;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(c), (n == 0) ? 64'd1 : 64'(n + 2));
    check({tag, "_busy_cycles"}, 64'(bcnt), (n == 0) ? 64'd0 : 64'(n + 1));
    check({tag, "_writes"}, 64'(wcnt), 64'(n));
    check({tag, "_rd_order"}, 64'(rd_bad), 64'd0);
    check({tag, "_wr_order"}, 64'(wr_bad), 64'd0);
    check({tag, "_port_rules"}, 64'(viol), 64'd0);
    @(negedge clk);
    check({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) bad++;
    check({tag, "_mem"}, 64'(bad), 64'd0);
  endtask

  task automatic reset_mid_copy();
    logic [DW-1:0] snap [0:DEPTH-1];
    int dones, writes, bad;
    snap = mem;
    @(negedge clk);
    start = 1'b1; src = 8'h30; dst = 8'h80; len = 8'd8;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_in_busy", 64'(busy), 64'd0);
    check("rst_in_we_b", 64'(we_b), 64'd0);
    check("rst_in_addr_a", 64'(addr_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_after_outputs", {busy, done, we_a, we_b, addr_a, addr_b, data_a, data_b}, 64'd0);
    dones = 0; writes = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
      if (we_b) writes++;
    end
    check("rst_no_done", 64'(dones), 64'd0);
    check("rst_no_writes", 64'(writes), 64'd0);
    check("rst_first_word", 64'(mem[8'h80]), 64'(snap[8'h30]));
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (i != 8'h80 && i != 8'h81 && mem[i] !== snap[i]) bad++;
    check("rst_untouched", 64'(bad), 64'd0);
  endtask

  initial begin
    int l, s, d, o;
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, we_a, we_b, addr_a, addr_b, data_a, data_b}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_reset_outputs", {busy, done, we_a, we_b, addr_a, addr_b, data_a, data_b}, 64'd0);

    mem[8'h10] = 16'h000A; mem[8'h11] = 16'h000B; mem[8'h12] = 16'h000C; mem[8'h13] = 16'h000D;
    run_copy("basic", 8'h10, 8'h40, 8'd4, 1'b0);
    check("basic_dst0", 64'(mem[8'h40]), 64'h000A);
    check("basic_dst3", 64'(mem[8'h43]), 64'h000D);
    check("basic_src0", 64'(mem[8'h10]), 64'h000A);

    run_copy("len0", 8'h05, 8'h06, 8'd0, 1'b0);

    mem[8'h20] = 16'd1; mem[8'h21] = 16'd2; mem[8'h22] = 16'd3; mem[8'h23] = 16'd4;
    run_copy("overlap", 8'h20, 8'h22, 8'd4, 1'b0);
    check("overlap_20", 64'(mem[8'h20]), 64'd1);
    check("overlap_21", 64'(mem[8'h21]), 64'd2);
    check("overlap_22", 64'(mem[8'h22]), 64'd1);
    check("overlap_25", 64'(mem[8'h25]), 64'd4);

    run_copy("wrap_src", 8'hFE, 8'h10, 8'd4, 1'b0);
    run_copy("same", 8'h50, 8'h50, 8'd5, 1'b0);
    run_copy("hold_start", 8'h60, 8'h90, 8'd3, 1'b1);

    reset_mid_copy();
    run_copy("after_rst", 8'h30, 8'h80, 8'd8, 1'b0);

    for (int it = 0; it < 24; it++) begin
      l = $urandom_range(1, 60);
      s = $urandom_range(0, DEPTH - l);
      case ($urandom_range(0, 2))
        0: begin
          o = $urandom_range(0, l - 1);
          d = (s + o + l <= DEPTH) ? s + o : $urandom_range(0, DEPTH - l);
        end
        1: begin
          o = $urandom_range(0, (s < l) ? s : l);
          d = s - o;
        end
        default: d = $urandom_range(0, DEPTH - l);
      endcase
      run_copy($sformatf("rand%0d", it), AW'(s), AW'(d), AW'(l), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
